wb_write_arbiter: RTL
=====================

Name: wb_write_arbiter

Overview:
Writeback-side arbiter. It drives the single write port of the 32x32 register file (RegWrite/WriteReg/WriteData) from two sources:
- the in-order pipeline writeback stage;
- a long-latency unit (load/mul/div) using a valid/ready handshake, buffered in a small FIFO.

It also keeps a busy scoreboard of destination registers with results outstanding, for the hazard unit. It sits between the WB stage and the register file.

Parameters:
XLEN, 32, data width
DEPTH, 4, long-latency FIFO entries (power of 2, >=2)
STARVE_LIMIT, 8, consecutive blocked cycles before the FIFO forces a slot (>=1)

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  synchronous, active-high
wb_valid  in  1  pipeline writeback valid
wb_rd  in  5  pipeline destination register
wb_data  in  XLEN  pipeline result
lu_valid  in  1  long-latency result valid
lu_ready  out  1  FIFO can accept
lu_rd  in  5  long-latency destination register
lu_data  in  XLEN  long-latency result
iss_valid  in  1  long-latency op issued this cycle
iss_rd  in  5  its destination register
stall_req  out  1  pipeline must hold its WB this cycle
busy  out  32  per-register outstanding-result flags
RegWrite  out  1  register file write enable (registered)
WriteReg  out  5  register file write address (registered)
WriteData  out  XLEN  register file write data (registered)

Behaviour:
- Reset (synchronous, active-high): RegWrite=0, WriteReg=0, WriteData=0, busy=0, FIFO empty, starve counter=0, lu_ready=0 while reset is high.
- lu_ready = !full && !reset. Push on lu_valid && lu_ready. lu_rd==0 is accepted and discarded, never stored.
- Selection each cycle, highest first:
  1. force = (cnt==STARVE_LIMIT) && !empty → pop FIFO. stall_req=1 combinationally; wb_valid is ignored and the pipeline re-presents next cycle.
  2. wb_valid && wb_rd!=0 → pipeline write.
  3. !empty → pop FIFO.
  4. Otherwise no write.
- Output latency: the chosen write appears on RegWrite/WriteReg/WriteData at the next rising edge, for exactly 1 cycle. When idle, RegWrite=0 and the address/data hold their last values.
- wb_rd==0 or lu_rd==0 never produces RegWrite=1.
- Starve counter:
  - increments when !empty and the FIFO was not popped;
  - resets to 0 on a pop or when empty;
  - saturates at STARVE_LIMIT.
- FIFO: circular, wrap-around pointers plus a count. Push and pop in the same cycle are allowed, count unchanged. A push into the empty FIFO is not poppable until the next cycle (no pass-through).
- Full FIFO: lu_ready=0; the source holds data.
- Scoreboard:
  - iss_valid && iss_rd!=0 sets busy[iss_rd].
  - A FIFO pop with rd R clears busy[R].
  - Set and clear of the same register in one cycle: set wins.
  - busy[0] is always 0.
  - Pipeline writes never touch busy.
- WAW between the pipeline and a pending FIFO entry is prevented upstream by stalling on busy. If it occurs anyway, writes retire in arbitration order (no kill).
- Reset mid-operation: FIFO contents and busy flags are discarded, and any in-flight output write is cancelled at that edge.

Optional Feature:
Macro WB_ARB_BYPASS_EN.
- Defined: adds inputs rs1[5], rs2[5], rf_rdata1[XLEN], rf_rdata2[XLEN] and outputs byp_rdata1[XLEN], byp_rdata2[XLEN].
- byp_rdataN = WriteData when RegWrite && WriteReg==rsN && rsN!=0, else rf_rdataN. This is combinational and hides the read-during-write of the register file.
- Not defined: these ports are absent; no bypass logic.

Test Plan:
- Reset, then idle → RegWrite=0, WriteReg=0, WriteData=0, busy=0, lu_ready=1 on the first cycle after reset drops.
- wb_valid=1, wb_rd=5, wb_data=0xDEADBEEF for 1 cycle → next cycle RegWrite=1, WriteReg=5, WriteData=0xDEADBEEF. The same with wb_rd=0 → RegWrite stays 0.
- iss_valid, iss_rd=7; 3 cycles later lu push rd=7, data=0x1234 with the pipeline idle → busy[7]=1 from issue+1. RegWrite/WriteReg=7/0x1234 two cycles after the push. busy[7]=0 after the pop edge.
- Push 4 entries back-to-back with wb_valid held high (rd=3) → lu_ready=0 after the 4th. After 8 blocked cycles, stall_req=1 for 1 cycle and the oldest FIFO entry is written. Order is preserved across all 4 pops with pointer wrap.
- Same-cycle iss_valid rd=9 and FIFO pop rd=9 → busy[9] remains 1. Reset asserted with a full FIFO → FIFO empty, busy=0, no write the following cycle.
- (WB_ARB_BYPASS_EN) RegWrite=1, WriteReg=4, WriteData=0xA5A5A5A5, rs1=4, rf_rdata1=0 → byp_rdata1=0xA5A5A5A5. With rs1=0 → byp_rdata1=rf_rdata1.

Source files
------------

// File: rtl/wb_write_arbiter.sv
// Writeback arbiter: merges pipeline WB and a FIFO-buffered long-latency source onto the
// register-file write port, with starvation forcing and a busy scoreboard. Optional macro: WB_ARB_BYPASS_EN.
module wb_write_arbiter #(
    parameter int XLEN         = 32,
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            wb_valid,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    input  logic            lu_valid,
    output logic            lu_ready,
    input  logic [4:0]      lu_rd,
    input  logic [XLEN-1:0] lu_data,
    input  logic            iss_valid,
    input  logic [4:0]      iss_rd,
`ifdef WB_ARB_BYPASS_EN
    input  logic [4:0]      rs1,
    input  logic [4:0]      rs2,
    input  logic [XLEN-1:0] rf_rdata1,
    input  logic [XLEN-1:0] rf_rdata2,
    output logic [XLEN-1:0] byp_rdata1,
    output logic [XLEN-1:0] byp_rdata2,
`endif
    output logic            stall_req,
    output logic [31:0]     busy,
    output logic            RegWrite,
    output logic [4:0]      WriteReg,
    output logic [XLEN-1:0] WriteData
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam int STV_W = $clog2(STARVE_LIMIT + 1);

    logic [4:0]      fifo_rd_q   [DEPTH];
    logic [XLEN-1:0] fifo_data_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [STV_W-1:0] starve_q, starve_d;
    logic [31:0]      busy_q, busy_d;
    logic             regwrite_q, regwrite_d;
    logic [4:0]       write_reg_q, write_reg_d;
    logic [XLEN-1:0]  write_data_q, write_data_d;

    logic fifo_empty, fifo_full, force_pop, wb_sel, pop, push;
    logic [4:0]      head_rd;
    logic [XLEN-1:0] head_data;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == CNT_W'(DEPTH));
    assign lu_ready   = !fifo_full && !reset;
    // rd==0 results are acknowledged to the source but never stored.
    assign push       = lu_valid && lu_ready && (lu_rd != 5'd0);
    assign head_rd    = fifo_rd_q[rd_ptr_q];
    assign head_data  = fifo_data_q[rd_ptr_q];
    assign force_pop  = (starve_q == STV_W'(STARVE_LIMIT)) && !fifo_empty;
    assign wb_sel     = !force_pop && wb_valid && (wb_rd != 5'd0);
    assign pop        = force_pop || (!wb_sel && !fifo_empty);
    assign stall_req  = force_pop;

    always_comb begin
        regwrite_d   = 1'b0;
        write_reg_d  = write_reg_q;
        write_data_d = write_data_q;
        wr_ptr_d     = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d     = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d      = count_q;
        starve_d     = starve_q;
        if (pop) begin
            regwrite_d   = 1'b1;
            write_reg_d  = head_rd;
            write_data_d = head_data;
        end else if (wb_sel) begin
            regwrite_d   = 1'b1;
            write_reg_d  = wb_rd;
            write_data_d = wb_data;
        end
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !push) begin
            count_d = count_q - CNT_W'(1);
        end
        if (pop || fifo_empty) begin
            starve_d = '0;
        end else if (starve_q != STV_W'(STARVE_LIMIT)) begin
            starve_d = starve_q + STV_W'(1);
        end
    end

    // Per-register scoreboard: an issue in the same cycle as the retiring pop keeps the flag set.
    assign busy_d[0] = 1'b0;
    generate
        for (genvar gi = 1; gi < 32; gi++) begin : g_busy
            assign busy_d[gi] = (iss_valid && (iss_rd == 5'(gi))) ||
                                (busy_q[gi] && !(pop && (head_rd == 5'(gi))));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            starve_q     <= '0;
            busy_q       <= '0;
            regwrite_q   <= 1'b0;
            write_reg_q  <= '0;
            write_data_q <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            starve_q     <= starve_d;
            busy_q       <= busy_d;
            regwrite_q   <= regwrite_d;
            write_reg_q  <= write_reg_d;
            write_data_q <= write_data_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_rd_q[wr_ptr_q]   <= lu_rd;
            fifo_data_q[wr_ptr_q] <= lu_data;
        end
    end

    assign busy      = busy_q;
    assign RegWrite  = regwrite_q;
    assign WriteReg  = write_reg_q;
    assign WriteData = write_data_q;

`ifdef WB_ARB_BYPASS_EN
    assign byp_rdata1 = (regwrite_q && (write_reg_q == rs1) && (rs1 != 5'd0)) ? write_data_q : rf_rdata1;
    assign byp_rdata2 = (regwrite_q && (write_reg_q == rs2) && (rs2 != 5'd0)) ? write_data_q : rf_rdata2;
`endif
endmodule
